// File: rtl/arb_pkg.sv
// Shared types and mode encodings for the RC4/Sobel memory-port arbiter.
package arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } arb_state_t;

    typedef enum logic {
        RC4 = 1'b0,
        SOB = 1'b1
    } req_id_t;

    localparam logic [1:0] MODE_IDLE  = 2'b00;
    localparam logic [1:0] MODE_READ  = 2'b01;
    localparam logic [1:0] MODE_WRITE = 2'b10;

    function automatic logic mode_valid(input logic [1:0] mode);
        return (mode == MODE_READ) || (mode == MODE_WRITE);
    endfunction

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// Bus bundle for mem_bus_arbiter: both requester ports plus the memory port.
// master = arbiter view, slave = requesters and memory wrapper.
interface mem_bus_arbiter_if #(
    parameter int ADDR_W = 20,
    parameter int DATA_W = 32
);
    logic [1:0]        rc4_mode_i;
    logic [ADDR_W-1:0] rc4_addr_i;
    logic [DATA_W-1:0] rc4_wdata_i;
    logic [DATA_W-1:0] rc4_rdata_o;
    logic              rc4_dfb_o;

    logic [1:0]        sob_mode_i;
    logic [ADDR_W-1:0] sob_addr_i;
    logic [DATA_W-1:0] sob_wdata_i;
    logic [DATA_W-1:0] sob_rdata_o;
    logic              sob_dfb_o;

    logic              mem_read_o;
    logic              mem_write_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [DATA_W-1:0] mem_wdata_o;
    logic [DATA_W-1:0] mem_rdata_i;
    logic              mem_ack_i;

    modport master (
        input  rc4_mode_i, rc4_addr_i, rc4_wdata_i,
        output rc4_rdata_o, rc4_dfb_o,
        input  sob_mode_i, sob_addr_i, sob_wdata_i,
        output sob_rdata_o, sob_dfb_o,
        output mem_read_o, mem_write_o, mem_addr_o, mem_wdata_o,
        input  mem_rdata_i, mem_ack_i
    );

    modport slave (
        output rc4_mode_i, rc4_addr_i, rc4_wdata_i,
        input  rc4_rdata_o, rc4_dfb_o,
        output sob_mode_i, sob_addr_i, sob_wdata_i,
        input  sob_rdata_o, sob_dfb_o,
        input  mem_read_o, mem_write_o, mem_addr_o, mem_wdata_o,
        output mem_rdata_i, mem_ack_i
    );

endinterface

// File: rtl/arb_req_capture.sv
// One-deep request latch for a single requester: holds the pending flag and
// the captured mode/addr/wdata until the arbiter signals completion via dfb.
module arb_req_capture
    import arb_pkg::*;
#(
    parameter int ADDR_W = 20,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              n_rst_i,
    input  logic [1:0]        mode_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              dfb_i,
    output logic              pending_o,
    output logic [1:0]        mode_o,
    output logic [ADDR_W-1:0] addr_o,
    output logic [DATA_W-1:0] wdata_o
);

    logic              pending_q, pending_d;
    logic [1:0]        mode_q, mode_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;

    // A requester may still be presenting its mode during its own dfb cycle;
    // capture is blocked then so the finished access is not re-queued.
    always_comb begin
        pending_d = pending_q;
        mode_d    = mode_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        if (dfb_i) begin
            pending_d = 1'b0;
        end else if (!pending_q && mode_valid(mode_i)) begin
            pending_d = 1'b1;
            mode_d    = mode_i;
            addr_d    = addr_i;
            wdata_d   = wdata_i;
        end
    end

    always_ff @(posedge clk or negedge n_rst_i) begin
        if (!n_rst_i) begin
            pending_q <= 1'b0;
            mode_q    <= MODE_IDLE;
            addr_q    <= '0;
            wdata_q   <= '0;
        end else begin
            pending_q <= pending_d;
            mode_q    <= mode_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
        end
    end

    assign pending_o = pending_q;
    assign mode_o    = mode_q;
    assign addr_o    = addr_q;
    assign wdata_o   = wdata_q;

endmodule

// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter sharing the external memory port between RC4 and Sobel.
// Build option ARB_TIMEOUT_EN adds an ACCESS timeout that aborts with err_o.
//
// state  | meaning
// IDLE   | no access in flight; pick a pending requester
// ACCESS | strobe driven from the granted latch, waiting for mem_ack_i
// RESP   | one-cycle dfb to the granted requester
module mem_bus_arbiter
    import arb_pkg::*;
#(
    parameter int ADDR_W         = 20,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                clk,
    input  logic                n_rst_i,
    mem_bus_arbiter_if.master   bus,
    output logic                busy_o,
    output logic                err_o
);

    logic              rc4_pend, sob_pend;
    logic [1:0]        rc4_mode, sob_mode;
    logic [ADDR_W-1:0] rc4_addr, sob_addr;
    logic [DATA_W-1:0] rc4_wdata, sob_wdata;
    logic              rc4_dfb, sob_dfb;

    arb_state_t        state_q, state_d;
    req_id_t           grant_q, grant_d;
    req_id_t           last_grant_q, last_grant_d;
    logic [DATA_W-1:0] rc4_rdata_q, rc4_rdata_d;
    logic [DATA_W-1:0] sob_rdata_q, sob_rdata_d;

    logic [1:0]        g_mode;
    logic [ADDR_W-1:0] g_addr;
    logic [DATA_W-1:0] g_wdata;

    arb_req_capture #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_cap_rc4 (
        .clk       (clk),
        .n_rst_i   (n_rst_i),
        .mode_i    (bus.rc4_mode_i),
        .addr_i    (bus.rc4_addr_i),
        .wdata_i   (bus.rc4_wdata_i),
        .dfb_i     (rc4_dfb),
        .pending_o (rc4_pend),
        .mode_o    (rc4_mode),
        .addr_o    (rc4_addr),
        .wdata_o   (rc4_wdata)
    );

    arb_req_capture #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_cap_sob (
        .clk       (clk),
        .n_rst_i   (n_rst_i),
        .mode_i    (bus.sob_mode_i),
        .addr_i    (bus.sob_addr_i),
        .wdata_i   (bus.sob_wdata_i),
        .dfb_i     (sob_dfb),
        .pending_o (sob_pend),
        .mode_o    (sob_mode),
        .addr_o    (sob_addr),
        .wdata_o   (sob_wdata)
    );

    assign g_mode  = (grant_q == RC4) ? rc4_mode  : sob_mode;
    assign g_addr  = (grant_q == RC4) ? rc4_addr  : sob_addr;
    assign g_wdata = (grant_q == RC4) ? rc4_wdata : sob_wdata;

`ifdef ARB_TIMEOUT_EN
    localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
    logic [CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;
    logic             abort_q, abort_d;
`endif

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        rc4_rdata_d  = rc4_rdata_q;
        sob_rdata_d  = sob_rdata_q;
`ifdef ARB_TIMEOUT_EN
        tmo_cnt_d    = tmo_cnt_q;
        abort_d      = abort_q;
`endif
        unique case (state_q)
            IDLE: begin
`ifdef ARB_TIMEOUT_EN
                tmo_cnt_d = '0;
                abort_d   = 1'b0;
`endif
                // last_grant only moves on a tie; lone grants leave the rotation alone.
                if (rc4_pend && sob_pend) begin
                    grant_d      = (last_grant_q == RC4) ? SOB : RC4;
                    last_grant_d = grant_d;
                    state_d      = ACCESS;
                end else if (rc4_pend) begin
                    grant_d = RC4;
                    state_d = ACCESS;
                end else if (sob_pend) begin
                    grant_d = SOB;
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                if (bus.mem_ack_i) begin
                    if (g_mode == MODE_READ) begin
                        if (grant_q == RC4) rc4_rdata_d = bus.mem_rdata_i;
                        else                sob_rdata_d = bus.mem_rdata_i;
                    end
                    state_d = RESP;
                end
`ifdef ARB_TIMEOUT_EN
                else if (tmo_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    if (grant_q == RC4) rc4_rdata_d = '0;
                    else                sob_rdata_d = '0;
                    abort_d = 1'b1;
                    state_d = RESP;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + CNT_W'(1);
                end
`endif
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst_i) begin
        if (!n_rst_i) begin
            state_q      <= IDLE;
            grant_q      <= RC4;
            last_grant_q <= SOB;
            rc4_rdata_q  <= '0;
            sob_rdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            rc4_rdata_q  <= rc4_rdata_d;
            sob_rdata_q  <= sob_rdata_d;
        end
    end

`ifdef ARB_TIMEOUT_EN
    always_ff @(posedge clk or negedge n_rst_i) begin
        if (!n_rst_i) begin
            tmo_cnt_q <= '0;
            abort_q   <= 1'b0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
            abort_q   <= abort_d;
        end
    end

    assign err_o = (state_q == RESP) && abort_q;
`else
    logic unused_tmo_cfg;
    assign unused_tmo_cfg = (TIMEOUT_CYCLES == 0);
    assign err_o = 1'b0;
`endif

    // Strobes and dfb decode straight from state so a reset drops them immediately.
    always_comb begin
        bus.mem_read_o  = 1'b0;
        bus.mem_write_o = 1'b0;
        bus.mem_addr_o  = '0;
        bus.mem_wdata_o = '0;
        if (state_q == ACCESS) begin
            bus.mem_read_o  = (g_mode == MODE_READ);
            bus.mem_write_o = (g_mode == MODE_WRITE);
            bus.mem_addr_o  = g_addr;
            bus.mem_wdata_o = g_wdata;
        end
    end

    assign rc4_dfb         = (state_q == RESP) && (grant_q == RC4);
    assign sob_dfb         = (state_q == RESP) && (grant_q == SOB);
    assign bus.rc4_dfb_o   = rc4_dfb;
    assign bus.sob_dfb_o   = sob_dfb;
    assign bus.rc4_rdata_o = rc4_rdata_q;
    assign bus.sob_rdata_o = sob_rdata_q;
    assign busy_o          = (state_q != IDLE);

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Scoreboard bench for mem_bus_arbiter: directed requests push expected memory
// accesses and responses; independent monitors pop and compare them.
module tb_mem_bus_arbiter;
    import arb_pkg::*;

    localparam int ADDR_W = 20;
    localparam int DATA_W = 32;
    localparam int TMO    = 4;

    logic clk = 1'b0;
    logic n_rst_i = 1'b0;
    logic busy_o, err_o;

    mem_bus_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    mem_bus_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT_CYCLES(TMO)) dut (
        .clk     (clk),
        .n_rst_i (n_rst_i),
        .bus     (bus),
        .busy_o  (busy_o),
        .err_o   (err_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic              wr;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        int                len;
        int                gap;
    } mem_exp_t;

    typedef struct {
        logic              id;
        logic [DATA_W-1:0] rdata;
        logic              err;
        int                cyc;
    } rsp_exp_t;

    mem_exp_t mem_q[$];
    rsp_exp_t rsp_q[$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_dfb_cyc = -100;
    int ack_delay = 0;
    logic stray_ack = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic fail_event(input string name);
        checks++;
        errors++;
        $display("FAIL %s actual=event required=none", name);
    endtask

    function automatic logic [DATA_W-1:0] mem_data(input logic [ADDR_W-1:0] a);
        return (a == 20'h00010) ? 32'hDEADBEEF : {12'h5A5, a};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input string name, input int budget);
        int n;
        n = 0;
        while ((rsp_q.size() != 0 || busy_o) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(name, 64'(rsp_q.size() == 0 && !busy_o), 64'd1);
    endtask

    // Memory wrapper model: ack after ack_delay strobe cycles (-1 = never).
    initial begin
        int scnt;
        scnt = 0;
        bus.mem_ack_i   = 1'b0;
        bus.mem_rdata_i = '0;
        forever begin
            @(posedge clk);
            #1;
            if (bus.mem_read_o || bus.mem_write_o) begin
                if (ack_delay >= 0 && scnt == ack_delay) begin
                    bus.mem_ack_i   = 1'b1;
                    bus.mem_rdata_i = bus.mem_write_o ? 32'hBAD0BAD0 : mem_data(bus.mem_addr_o);
                end else begin
                    bus.mem_ack_i   = 1'b0;
                    bus.mem_rdata_i = 32'h0;
                end
                scnt++;
            end else begin
                bus.mem_ack_i   = stray_ack;
                bus.mem_rdata_i = 32'hFFFFFFFF;
                scnt = 0;
            end
        end
    end

    // Memory-side monitor
    initial begin
        logic prev, strobe;
        int start;
        mem_exp_t cur;
        prev = 1'b0;
        start = 0;
        cur.len = -1;
        forever begin
            @(negedge clk);
            strobe = bus.mem_read_o || bus.mem_write_o;
            if (bus.mem_read_o && bus.mem_write_o) fail_event("both_strobes");
            if (strobe && !prev) begin
                start = cyc;
                if (mem_q.size() == 0) begin
                    fail_event("unexpected_strobe");
                    cur.len = -1;
                end else begin
                    cur = mem_q.pop_front();
                    check("strobe_dir", 64'(bus.mem_write_o), 64'(cur.wr));
                    check("mem_addr", 64'(bus.mem_addr_o), 64'(cur.addr));
                    if (cur.wr) check("mem_wdata", 64'(bus.mem_wdata_o), 64'(cur.wdata));
                    if (cur.gap >= 0) check("dfb_to_strobe", 64'(cyc - last_dfb_cyc), 64'(cur.gap));
                end
            end else if (!strobe && prev && cur.len >= 0) begin
                check("strobe_len", 64'(cyc - start), 64'(cur.len));
            end
            prev = strobe;
        end
    end

    // Response monitor
    initial begin
        logic prev_dfb, any_dfb;
        rsp_exp_t e;
        prev_dfb = 1'b0;
        forever begin
            @(negedge clk);
            any_dfb = bus.rc4_dfb_o || bus.sob_dfb_o;
            if (err_o && !any_dfb) fail_event("err_without_dfb");
            if (any_dfb) begin
                check("dfb_pulse", {62'd0, prev_dfb, bus.rc4_dfb_o & bus.sob_dfb_o}, 64'd0);
                if (rsp_q.size() == 0) begin
                    fail_event("unexpected_dfb");
                end else begin
                    e = rsp_q.pop_front();
                    check("dfb_id", 64'(bus.sob_dfb_o), 64'(e.id));
                    check("rdata", 64'(e.id ? bus.sob_rdata_o : bus.rc4_rdata_o), 64'(e.rdata));
                    check("err", 64'(err_o), 64'(e.err));
                    if (e.cyc >= 0) check("dfb_cycle", 64'(cyc), 64'(e.cyc));
                end
                last_dfb_cyc = cyc;
            end
            prev_dfb = any_dfb;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        int n;
        logic seen;
        bus.rc4_mode_i = MODE_IDLE; bus.rc4_addr_i = '0; bus.rc4_wdata_i = '0;
        bus.sob_mode_i = MODE_IDLE; bus.sob_addr_i = '0; bus.sob_wdata_i = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_strobes", {58'd0, bus.mem_read_o, bus.mem_write_o, bus.rc4_dfb_o,
                              bus.sob_dfb_o, busy_o, err_o}, 64'd0);
        check("rst_bus", {12'd0, bus.mem_addr_o, bus.mem_wdata_o}, 64'd0);
        check("rst_rdata", {bus.rc4_rdata_o, bus.sob_rdata_o}, 64'd0);
        n_rst_i = 1'b1;

        // Single RC4 read, ack on third strobe cycle
        tick();
        ack_delay = 2;
        bus.rc4_mode_i = MODE_READ; bus.rc4_addr_i = 20'h00010;
        mem_q.push_back('{1'b0, 20'h00010, 32'h0, 3, -1});
        rsp_q.push_back('{1'b0, 32'hDEADBEEF, 1'b0, cyc + 5});
        tick();
        bus.rc4_mode_i = MODE_IDLE;
        wait_done("t1_done", 30);

        // Simultaneous pair: RC4 wins first tie
        tick();
        ack_delay = 0;
        bus.rc4_mode_i = MODE_WRITE; bus.rc4_addr_i = 20'h00004; bus.rc4_wdata_i = 32'hA5A5A5A5;
        bus.sob_mode_i = MODE_READ;  bus.sob_addr_i = 20'h00100;
        mem_q.push_back('{1'b1, 20'h00004, 32'hA5A5A5A5, 1, -1});
        mem_q.push_back('{1'b0, 20'h00100, 32'h0, 1, 2});
        rsp_q.push_back('{1'b0, 32'hDEADBEEF, 1'b0, cyc + 3});
        rsp_q.push_back('{1'b1, 32'h5A500100, 1'b0, cyc + 6});
        tick();
        bus.rc4_mode_i = MODE_IDLE; bus.sob_mode_i = MODE_IDLE;
        wait_done("t2a_done", 30);

        // Next pair: Sobel wins
        tick();
        bus.rc4_mode_i = MODE_READ; bus.rc4_addr_i = 20'h00020;
        bus.sob_mode_i = MODE_READ; bus.sob_addr_i = 20'h00200;
        mem_q.push_back('{1'b0, 20'h00200, 32'h0, 1, -1});
        mem_q.push_back('{1'b0, 20'h00020, 32'h0, 1, 2});
        rsp_q.push_back('{1'b1, 32'h5A500200, 1'b0, cyc + 3});
        rsp_q.push_back('{1'b0, 32'h5A500020, 1'b0, cyc + 6});
        tick();
        bus.rc4_mode_i = MODE_IDLE; bus.sob_mode_i = MODE_IDLE;
        wait_done("t2b_done", 30);

        // RC4 holds write mode through its dfb cycle
        tick();
        ack_delay = 1;
        bus.rc4_mode_i = MODE_WRITE; bus.rc4_addr_i = 20'h00008; bus.rc4_wdata_i = 32'h11223344;
        mem_q.push_back('{1'b1, 20'h00008, 32'h11223344, 2, -1});
        rsp_q.push_back('{1'b0, 32'h5A500020, 1'b0, cyc + 4});
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            seen = bus.rc4_dfb_o;
        end
        check("t3_dfb_seen", 64'(seen), 64'd1);
        tick();
        bus.rc4_mode_i = MODE_IDLE;
        repeat (4) tick();
        check("t3_idle_after", {62'd0, busy_o, bus.mem_write_o}, 64'd0);

        // Illegal Sobel mode plus stray ack while idle
        tick();
        stray_ack = 1'b1;
        bus.sob_mode_i = 2'b11; bus.sob_addr_i = 20'h00333;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("t4_ignored", {60'd0, busy_o, bus.sob_dfb_o, bus.mem_read_o, bus.mem_write_o}, 64'd0);
        end
        tick();
        bus.sob_mode_i = MODE_IDLE;
        stray_ack = 1'b0;

        // Reset during ACCESS
        tick();
        ack_delay = -1;
        bus.rc4_mode_i = MODE_READ; bus.rc4_addr_i = 20'h00030;
        mem_q.push_back('{1'b0, 20'h00030, 32'h0, -1, -1});
        tick();
        bus.rc4_mode_i = MODE_IDLE;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            seen = bus.mem_read_o;
        end
        check("t5_strobe_seen", 64'(seen), 64'd1);
        #2;
        n_rst_i = 1'b0;
        #1;
        check("t5_async_drop", {62'd0, bus.mem_read_o, busy_o}, 64'd0);
        check("t5_rdata_cleared", 64'(bus.rc4_rdata_o), 64'd0);
        tick();
        n_rst_i = 1'b1;
        tick();
        ack_delay = 0;
        bus.rc4_mode_i = MODE_READ; bus.rc4_addr_i = 20'h00040;
        bus.sob_mode_i = MODE_READ; bus.sob_addr_i = 20'h00400;
        mem_q.push_back('{1'b0, 20'h00040, 32'h0, 1, -1});
        mem_q.push_back('{1'b0, 20'h00400, 32'h0, 1, 2});
        rsp_q.push_back('{1'b0, 32'h5A500040, 1'b0, cyc + 3});
        rsp_q.push_back('{1'b1, 32'h5A500400, 1'b0, cyc + 6});
        tick();
        bus.rc4_mode_i = MODE_IDLE; bus.sob_mode_i = MODE_IDLE;
        wait_done("t5_done", 30);

`ifdef ARB_TIMEOUT_EN
        // No ack: abort after TMO strobe cycles
        tick();
        ack_delay = -1;
        bus.rc4_mode_i = MODE_READ; bus.rc4_addr_i = 20'h00050;
        mem_q.push_back('{1'b0, 20'h00050, 32'h0, TMO, -1});
        rsp_q.push_back('{1'b0, 32'h0, 1'b1, cyc + 2 + TMO});
        tick();
        bus.rc4_mode_i = MODE_IDLE;
        wait_done("t6_done", 30);
`endif

        repeat (3) tick();
        check("mem_q_empty", 64'(mem_q.size()), 64'd0);
        check("rsp_q_empty", 64'(rsp_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares the single external memory port between the RC4 decryption core and the Sobel edge-detection core.
- Captures one pending request per requester and grants the port round-robin.
- Drives the memory strobes, returns read data, and pulses each requester's dfb ("done from bus") when its access completes.
- Sits between both cores and the memory wrapper. It is the only master of the mem_* port.

Parameters:
- ADDR_W, 20, address width (matches the pixel counter width).
- DATA_W, 32, data width.
- TIMEOUT_CYCLES, 255, ACCESS cycles without ack before abort (used only with ARB_TIMEOUT_EN).

Ports:
- clk  in  1  system clock
- n_rst_i  in  1  asynchronous, active-low reset
- rc4_mode_i  in  2  RC4 request: 00 idle, 01 read, 10 write, 11 illegal
- rc4_addr_i  in  ADDR_W  RC4 address
- rc4_wdata_i  in  DATA_W  RC4 write data
- rc4_rdata_o  out  DATA_W  RC4 read data, valid while rc4_dfb_o=1
- rc4_dfb_o  out  1  RC4 access-complete pulse
- sob_mode_i  in  2  Sobel request, same encoding as rc4_mode_i
- sob_addr_i  in  ADDR_W  Sobel address
- sob_wdata_i  in  DATA_W  Sobel write data
- sob_rdata_o  out  DATA_W  Sobel read data, valid while sob_dfb_o=1
- sob_dfb_o  out  1  Sobel access-complete pulse
- mem_read_o  out  1  memory read strobe
- mem_write_o  out  1  memory write strobe
- mem_addr_o  out  ADDR_W  memory address
- mem_wdata_o  out  DATA_W  memory write data
- mem_rdata_i  in  DATA_W  memory read data, valid with mem_ack_i
- mem_ack_i  in  1  memory access complete
- busy_o  out  1  high in every state except IDLE
- err_o  out  1  timeout-abort pulse, coincident with dfb

Behaviour:
- Clocking and reset: one clock, clk. Reset is asynchronous and active-low on n_rst_i.
- Reset values:
  - All outputs 0. Both pending flags 0. State IDLE. Timeout counter 0.
  - last_grant = SOB, so RC4 wins the first tie.
- Request capture (per requester):
  - Mode 01 or 10 seen while not pending sets pending and latches mode, addr and wdata at the clock edge.
  - Mode 11 is ignored.
  - Any mode change while pending is ignored.
  - No capture in a cycle where that requester's dfb is 1. This covers a write requester still holding mode 10 during its dfb cycle.
  - Pending clears on the edge that ends the dfb cycle.
- State machine (enum of IDLE, ACCESS, RESP):
  - IDLE:
    - Exactly one requester pending: grant it.
    - Both pending: grant the requester that is not last_grant, then update last_grant.
    - Any grant: next state ACCESS.
    - None pending: stay in IDLE.
  - ACCESS:
    - mem_addr_o and mem_wdata_o come from the granted latch. mem_read_o or mem_write_o is held per the latched mode.
    - Outputs are combinational from state and latch; all are 0 outside ACCESS.
    - On mem_ack_i=1, latch mem_rdata_i (reads only; write responses keep the previous rdata) and go to RESP.
  - RESP:
    - Granted requester's dfb=1 for exactly one cycle. Its rdata_o holds the latched value and stays stable until its next completion.
    - Next state IDLE.
- Latency: request in cycle N, strobe from N+2. If ack arrives in N+2, dfb is in N+3. Minimum request-to-dfb is 3 cycles.
- Back-to-back: while one requester is serviced, the other's capture proceeds. It is granted on the IDLE cycle following RESP.
- mem_ack_i outside ACCESS is ignored.
- Reset mid-operation: strobes and dfb drop asynchronously. Pending requests are lost; requesters re-issue after reset.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- Defined:
  - An 8-bit+ counter runs in ACCESS and clears on entry.
  - When it reaches TIMEOUT_CYCLES with no ack: drop the strobe, go to RESP, and assert dfb and err_o together.
  - rdata_o is forced to 0 for that response.
- Undefined: ACCESS waits for ack indefinitely and err_o is tied 0. The port list is identical either way.

Decomposition:
- Package arb_pkg:
  - arb_state_t (IDLE, ACCESS, RESP).
  - Mode constants MODE_IDLE=2'b00, MODE_READ=2'b01, MODE_WRITE=2'b10.
  - Requester ID type req_id_t (RC4=0, SOB=1).
- Sub-module arb_req_capture, instantiated twice. It holds the pending flag, the mode/addr/wdata latch, the capture-suppress-on-dfb rule and the clear-on-dfb rule.

Test Plan:
- RC4 mode=01, addr=0x00010, held one cycle; ack 2 cycles after strobe with rdata=0xDEADBEEF -> mem_read_o=1 at addr 0x00010 for 3 cycles; rc4_dfb_o=1 one cycle with rc4_rdata_o=0xDEADBEEF.
- Both cores issue in the same cycle (RC4 write 0xA5A5A5A5 to 0x00004, Sobel read 0x00100); ack immediate -> RC4 serviced first, Sobel strobe starts 2 cycles after rc4_dfb_o. On the next simultaneous pair, Sobel wins.
- RC4 holds mode=10 through its dfb cycle -> exactly one mem_write_o burst, no second capture, busy_o returns to 0.
- Mode=11 from Sobel for 5 cycles -> no strobe, busy_o stays 0, sob_dfb_o stays 0.
- Assert n_rst_i=0 during ACCESS -> mem_read_o drops immediately. After release, first tie goes to RC4.
- With ARB_TIMEOUT_EN and TIMEOUT_CYCLES=4, no ack -> strobe lasts 4 cycles; dfb and err_o high together with rdata_o=0.
